// File: rtl/adc_pkg.sv
// Shared widths, sequencer state type and channel-mask helpers for the ADC scan sequencer.
package adc_pkg;

  localparam int unsigned ADC_N_CH   = 8;
  localparam int unsigned ADC_DATA_W = 12;
  localparam int unsigned ADC_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    ACK
  } adc_seq_state_t;

  // Lowest enabled channel; 0 for an empty mask.
  function automatic logic [ADC_ADDR_W-1:0] lowest_set_bit(input logic [ADC_N_CH-1:0] mask);
    logic [ADC_ADDR_W-1:0] res;
    res = '0;
    for (int i = int'(ADC_N_CH) - 1; i >= 0; i--) begin
      if (mask[i]) res = ADC_ADDR_W'(i);
    end
    return res;
  endfunction

  // Highest enabled channel; 0 for an empty mask.
  function automatic logic [ADC_ADDR_W-1:0] highest_set_bit(input logic [ADC_N_CH-1:0] mask);
    logic [ADC_ADDR_W-1:0] res;
    res = '0;
    for (int i = 0; i < int'(ADC_N_CH); i++) begin
      if (mask[i]) res = ADC_ADDR_W'(i);
    end
    return res;
  endfunction

  // Next enabled channel above cur, wrapping to the lowest; a lone channel wraps to itself.
  function automatic logic [ADC_ADDR_W-1:0] next_set_bit(input logic [ADC_N_CH-1:0]   mask,
                                                         input logic [ADC_ADDR_W-1:0] cur);
    logic [ADC_ADDR_W-1:0] res;
    logic [ADC_ADDR_W-1:0] idx;
    logic                  found;
    res   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= ADC_N_CH; i++) begin
      idx = cur + ADC_ADDR_W'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single level signal crossing into the clk domain.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan controller: steps through enabled channels, handshakes with the ADC capture block
// and compensates its one-frame address pipeline when storing per-channel results.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned N_CH        = ADC_N_CH,
  parameter int unsigned DATA_W      = ADC_DATA_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cont,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic                   adc_ready,
  input  logic [DATA_W-1:0]      d_signal,
  output logic                   ctl_valid,
  output logic                   adc_ack,
  output logic [ADC_ADDR_W-1:0]  address,
  output logic                   sample_valid,
  output logic [ADC_ADDR_W-1:0]  sample_chan,
  output logic [DATA_W-1:0]      sample_data,
  output logic                   scan_done,
  output logic                   busy,
  output logic                   err,
  output logic [N_CH*DATA_W-1:0] results
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  adc_seq_state_t        state_q, state_n;
  logic [N_CH-1:0]       mask_q, mask_n;
  logic [ADC_ADDR_W-1:0] cur_ch_q, cur_ch_n;
  logic [ADC_ADDR_W-1:0] prev_ch_q, prev_ch_n;
  logic                  prev_valid_q, prev_valid_n;
  logic                  last_q, last_n;
  logic [WD_W-1:0]       wd_q, wd_n;
  logic                  rdy_s, rdy_d;
  logic                  rdy_rise_c, timeout_c, wr_en_c;
  logic [ADC_ADDR_W-1:0] address_n, sample_chan_n;
  logic [DATA_W-1:0]     sample_data_n;
  logic                  adc_ack_n, sample_valid_n, scan_done_n, err_n, busy_n;

  // Bring the capture block's conversion-done flag into the clk domain.
  sync_bit #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk (clk),
    .rst (rst),
    .d   (adc_ready),
    .q   (rdy_s)
  );

  assign rdy_rise_c = rdy_s & ~rdy_d;
  assign timeout_c  = (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    state_n        = state_q;
    mask_n         = mask_q;
    cur_ch_n       = cur_ch_q;
    prev_ch_n      = prev_ch_q;
    prev_valid_n   = prev_valid_q;
    last_n         = last_q;
    address_n      = address;
    adc_ack_n      = adc_ack;
    sample_valid_n = 1'b0;
    sample_chan_n  = sample_chan;
    sample_data_n  = sample_data;
    scan_done_n    = 1'b0;
    err_n          = err;
    wr_en_c        = 1'b0;

    case (state_q)
      IDLE: begin
        if ((start | cont) && ch_mask != '0) begin
          mask_n       = ch_mask;
          cur_ch_n     = lowest_set_bit(ch_mask);
          address_n    = lowest_set_bit(ch_mask);
          prev_valid_n = 1'b0;
          last_n       = 1'b0;
          err_n        = 1'b0;
          state_n      = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (rdy_rise_c) begin
          // This frame's result belongs to the channel addressed in the previous frame.
          if (prev_valid_q) begin
            wr_en_c        = 1'b1;
            sample_valid_n = 1'b1;
            sample_chan_n  = prev_ch_q;
            sample_data_n  = d_signal;
          end
          last_n       = prev_valid_q && (prev_ch_q == highest_set_bit(mask_q));
          prev_ch_n    = cur_ch_q;
          prev_valid_n = 1'b1;
          cur_ch_n     = next_set_bit(mask_q, cur_ch_q);
          address_n    = next_set_bit(mask_q, cur_ch_q);
          adc_ack_n    = 1'b1;
          state_n      = ACK;
        end else if (timeout_c) begin
          err_n     = 1'b1;
          adc_ack_n = 1'b0;
          state_n   = IDLE;
        end
      end
      ACK: begin
        if (!rdy_s) begin
          adc_ack_n = 1'b0;
          state_n   = WAIT_RDY;
          if (last_q) begin
            scan_done_n = 1'b1;
            // Rescan keeps the pipeline primed; the new mask steers stepping from the next frame.
            if (cont && ch_mask != '0) mask_n  = ch_mask;
            else                       state_n = IDLE;
          end
        end else if (timeout_c) begin
          err_n     = 1'b1;
          adc_ack_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: begin
        adc_ack_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    if (state_n != state_q || state_q == IDLE) wd_n = '0;
    else                                       wd_n = wd_q + WD_W'(1);
  end

  // FSM state, sequencing context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      cur_ch_q     <= '0;
      prev_ch_q    <= '0;
      prev_valid_q <= 1'b0;
      last_q       <= 1'b0;
      wd_q         <= '0;
      rdy_d        <= 1'b0;
      address      <= '0;
      adc_ack      <= 1'b0;
      sample_valid <= 1'b0;
      sample_chan  <= '0;
      sample_data  <= '0;
      scan_done    <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      ctl_valid    <= 1'b0;
    end else begin
      state_q      <= state_n;
      mask_q       <= mask_n;
      cur_ch_q     <= cur_ch_n;
      prev_ch_q    <= prev_ch_n;
      prev_valid_q <= prev_valid_n;
      last_q       <= last_n;
      wd_q         <= wd_n;
      rdy_d        <= rdy_s;
      address      <= address_n;
      adc_ack      <= adc_ack_n;
      sample_valid <= sample_valid_n;
      sample_chan  <= sample_chan_n;
      sample_data  <= sample_data_n;
      scan_done    <= scan_done_n;
      err          <= err_n;
      busy         <= busy_n;
      ctl_valid    <= busy_n;
    end
  end

  // Per-channel latest-result register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      results <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (wr_en_c && prev_ch_q == ADC_ADDR_W'(k)) results[k*DATA_W +: DATA_W] <= d_signal;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: capture-block model returning 0x100 + previous frame's address.
module tb_adc_scan_sequencer;

  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cont;
  logic [7:0]  ch_mask;
  logic        adc_ready = 1'b0;
  logic [11:0] d_signal = '0;
  logic        ctl_valid, adc_ack, sample_valid, scan_done, busy, err;
  logic [2:0]  address, sample_chan;
  logic [11:0] sample_data;
  logic [95:0] results;

  int checks = 0;
  int errors = 0;
  int n_samp = 0;
  int n_done = 0;
  int frames = 0;
  int exp_q[$];
  logic [11:0] res_m [8];

  logic       adc_stuck = 1'b0;
  logic       hold_ready = 1'b0;
  logic [2:0] frame_addr = '0;
  logic [2:0] prev_addr = '0;
  int         m_len, m_k;

  typedef struct {
    logic [7:0] mask;
    int         exp_s;
    int         exp_d;
    int         exp_f;
  } vec_t;
  vec_t tbl [6];

  adc_scan_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cont         (cont),
    .ch_mask      (ch_mask),
    .adc_ready    (adc_ready),
    .d_signal     (d_signal),
    .ctl_valid    (ctl_valid),
    .adc_ack      (adc_ack),
    .address      (address),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .scan_done    (scan_done),
    .busy         (busy),
    .err          (err),
    .results      (results)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture block model: one frame per pass while the sequencer is busy.
  always begin : adc_model
    @(negedge clk);
    if (ctl_valid === 1'b1) begin
      frame_addr = address;
      m_len = $urandom_range(2, 8);
      repeat (m_len) @(negedge clk);
      if (adc_stuck) begin
        m_k = 0;
        while (ctl_valid && m_k < 3 * TIMEOUT) begin @(negedge clk); m_k++; end
      end else begin
        d_signal  = 12'h100 + 12'(prev_addr);
        adc_ready = 1'b1;
        m_k = 0;
        while (!adc_ack && ctl_valid && m_k < 100) begin @(negedge clk); m_k++; end
        m_k = 0;
        while (hold_ready && ctl_valid && m_k < 10000) begin @(negedge clk); m_k++; end
        adc_ready = 1'b0;
        m_k = 0;
        while (adc_ack && m_k < 100) begin @(negedge clk); m_k++; end
        prev_addr = frame_addr;
        frames++;
      end
    end
  end

  // Scoreboard: every written sample must match the next expected channel and its data.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (sample_valid) begin
        n_samp++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got chan %0d, required no sample", sample_chan);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("sample_chan", 32'(sample_chan), 32'(e));
          chk("sample_data", 32'(sample_data), 32'h100 + 32'(e));
          chk("results_slot", 32'(results[e*12 +: 12]), 32'h100 + 32'(e));
        end
      end
      if (scan_done) n_done++;
      if (scan_done || sample_valid) chk("done_sample_overlap", 32'(scan_done & sample_valid), 0);
    end
  end

  task automatic check_results(input string tag);
    logic [95:0] rm;
    for (int i = 0; i < 8; i++) rm[i*12 +: 12] = res_m[i];
    checks++;
    if (results !== rm) begin
      errors++;
      $display("FAIL %s_results: got %h expected %h", tag, results, rm);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic run_scan(input logic [7:0] m, input int exp_s, input int exp_d,
                          input int exp_f, input string tag);
    int s0, d0, f0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        exp_q.push_back(i);
        res_m[i] = 12'h100 + 12'(i);
      end
    end
    s0 = n_samp; d0 = n_done; f0 = frames;
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ch_mask = 8'($urandom);
    wait_idle({tag, "_idle"});
    repeat (3) @(negedge clk);
    chk({tag, "_samples"}, 32'(n_samp - s0), 32'(exp_s));
    chk({tag, "_scan_done"}, 32'(n_done - d0), 32'(exp_d));
    chk({tag, "_frames"}, 32'(frames - f0), 32'(exp_f));
    chk({tag, "_pending"}, 32'(exp_q.size()), 0);
    chk({tag, "_err"}, 32'(err), 0);
    exp_q.delete();
    check_results(tag);
  endtask

  function automatic int popc(input logic [7:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(m[i]);
    return c;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : main
    int cnt, k, d0, f0, cyc;
    logic seen_busy, seen_ack;

    tbl[0] = '{8'h05, 2, 1, 3};
    tbl[1] = '{8'h80, 1, 1, 2};
    tbl[2] = '{8'h00, 0, 0, 0};
    tbl[3] = '{8'hFF, 8, 1, 9};
    tbl[4] = '{8'h81, 2, 1, 3};
    tbl[5] = '{8'h10, 1, 1, 2};

    rst = 1'b1; start = 1'b0; cont = 1'b0; ch_mask = '0;
    for (int i = 0; i < 8; i++) res_m[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ctl_valid", 32'(ctl_valid), 0);
    chk("reset_ack", 32'(adc_ack), 0);
    chk("reset_address", 32'(address), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_results_nonzero", 32'(results != '0), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single-shot scans.
    for (int i = 0; i < 6; i++) run_scan(tbl[i].mask, tbl[i].exp_s, tbl[i].exp_d, tbl[i].exp_f,
                                         $sformatf("tbl%0d", i));

    // Random single-shot scans against popcount-derived expectations.
    for (int i = 0; i < 15; i++) begin
      logic [7:0] m;
      int p;
      m = 8'($urandom_range(0, 255));
      p = popc(m);
      run_scan(m, p, (p != 0) ? 1 : 0, (p != 0) ? p + 1 : 0, $sformatf("rnd%0d", i));
    end

    // Empty mask: start and cont both ignored.
    cnt = n_samp; seen_busy = 1'b0; seen_ack = 1'b0;
    ch_mask = '0; start = 1'b1; cont = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_busy |= busy;
      seen_ack  |= adc_ack;
    end
    cont = 1'b0;
    chk("zero_mask_busy", 32'(seen_busy), 0);
    chk("zero_mask_ack", 32'(seen_ack), 0);
    chk("zero_mask_samples", 32'(n_samp - cnt), 0);

    // Continuous single-channel scan: 5 frames, 4 samples of ch7.
    for (int i = 0; i < 4; i++) exp_q.push_back(7);
    res_m[7] = 12'h107;
    d0 = n_done; f0 = frames; cnt = 0; k = 0;
    ch_mask = 8'h80; cont = 1'b1;
    while (cnt < 4 && k < 2000) begin
      @(negedge clk); k++;
      if (sample_valid) begin
        cnt++;
        chk("cont_address", 32'(address), 7);
      end
    end
    cont = 1'b0;
    wait_idle("cont_idle");
    repeat (3) @(negedge clk);
    chk("cont_samples", 32'(cnt), 4);
    chk("cont_scan_done", 32'(n_done - d0), 4);
    chk("cont_frames", 32'(frames - f0), 5);
    chk("cont_pending", 32'(exp_q.size()), 0);
    chk("cont_address_end", 32'(address), 7);
    exp_q.delete();
    check_results("cont");

    // Mask change mid-scan: old scan ends ch0,ch1; the in-flight ch0 and ch1 results land,
    // then the new mask steps ch4,ch5.
    exp_q = '{0, 1, 0, 1, 4, 5};
    res_m[0] = 12'h100; res_m[1] = 12'h101; res_m[4] = 12'h104; res_m[5] = 12'h105;
    d0 = n_done; cnt = 0; k = 0;
    ch_mask = 8'h03; cont = 1'b1;
    while (cnt < 6 && k < 3000) begin
      @(negedge clk); k++;
      if (sample_valid) begin
        cnt++;
        if (cnt == 1) ch_mask = 8'h30;
        if (cnt == 6) cont = 1'b0;
      end
    end
    cont = 1'b0;
    wait_idle("switch_idle");
    repeat (3) @(negedge clk);
    chk("switch_samples", 32'(cnt), 6);
    chk("switch_scan_done", 32'(n_done - d0), 2);
    chk("switch_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
    check_results("switch");

    // Ready never arrives: watchdog abort, sticky err, cleared by next start.
    adc_stuck = 1'b1; d0 = n_done;
    ch_mask = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (busy && cyc < TIMEOUT + 50) begin @(negedge clk); cyc++; end
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_err", 32'(err), 1);
    chk("timeout_ack", 32'(adc_ack), 0);
    chk("timeout_cycles_in_window", 32'(cyc >= TIMEOUT - 3 && cyc <= TIMEOUT + 3), 1);
    chk("timeout_no_scan_done", 32'(n_done - d0), 0);
    adc_stuck = 1'b0;
    repeat (4) @(negedge clk);
    chk("timeout_err_sticky", 32'(err), 1);
    run_scan(8'h02, 1, 1, 2, "after_timeout");

    // Reset while parked in ACK clears everything at once.
    hold_ready = 1'b1;
    ch_mask = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    while (!adc_ack && k < 200) begin @(negedge clk); k++; end
    chk("rst_reach_ack", 32'(adc_ack), 1);
    chk("rst_results_before", 32'(results != '0), 1);
    rst = 1'b1;
    #1;
    chk("rst_ack_cleared", 32'(adc_ack), 0);
    chk("rst_busy_cleared", 32'(busy), 0);
    chk("rst_address_cleared", 32'(address), 0);
    chk("rst_results_cleared", 32'(results != '0), 0);
    @(negedge clk);
    rst = 1'b0;
    hold_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) res_m[i] = '0;
    repeat (4) @(negedge clk);
    run_scan(8'h01, 1, 1, 2, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
